gray_codec: RTL and testbench



---
 rtl/gray_codec_pkg.sv | 24 ++
 rtl/gray_to_bin_comb.sv | 21 ++
 rtl/gray_codec.sv | 98 +++++++++
 tb/tb_gray_codec.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/gray_codec_pkg.sv
// Shared constants and reference conversion functions for the Gray codec.
package gray_codec_pkg;

  localparam int unsigned GRAY_W_MAX = 32;

  // Binary to Gray: each bit XORed with its upper neighbour.
  function automatic logic [GRAY_W_MAX-1:0] bin2gray(input logic [GRAY_W_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: running XOR from the MSB downward.
  function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] g);
    logic [GRAY_W_MAX-1:0] b;
    logic                  acc;
    acc = 1'b0;
    b   = '0;
    for (int i = GRAY_W_MAX - 1; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin_comb.sv
// Combinational Gray-to-binary decoder (prefix XOR from the MSB).
module gray_to_bin_comb #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  logic acc;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    acc   = 1'b0;
    bin_o = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      acc      = acc ^ gray_i[i];
      bin_o[i] = acc;
    end
  end

endmodule

// File: rtl/gray_codec.sv
// Registered two-lane binary/Gray converter, 1-cycle latency.
// Optional round-trip checker enabled by defining GRAY_CODEC_CHECK_EN.
module gray_codec
  import gray_codec_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] bin_in,
  input  logic [WIDTH-1:0] gray_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             chk_err
);

  if (WIDTH < 2 || WIDTH > GRAY_W_MAX) begin : g_width_check
    $error("gray_codec: WIDTH out of range");
  end

  logic [WIDTH-1:0] enc_gray;
  logic [WIDTH-1:0] dec_bin;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] bin_q, bin_d;

  assign enc_gray = bin_in ^ (bin_in >> 1);

  gray_to_bin_comb #(
    .WIDTH (WIDTH)
  ) u_dec (
    .gray_i (gray_in),
    .bin_o  (dec_bin)
  );

  // Next state: capture on accepted samples, hold data otherwise.
  always_comb begin
    out_valid_d = in_valid;
    gray_d      = gray_q;
    bin_d       = bin_q;
    if (in_valid) begin
      gray_d = enc_gray;
      bin_d  = dec_bin;
    end
  end

  // Output stage; synchronous reset wins over a same-edge sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      gray_q      <= '0;
      bin_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      gray_q      <= gray_d;
      bin_q       <= bin_d;
    end
  end

  assign out_valid = out_valid_q;
  assign gray_out  = gray_q;
  assign bin_out   = bin_q;

`ifdef GRAY_CODEC_CHECK_EN
  logic [WIDTH-1:0] chk_bin;
  logic             chk_err_q, chk_err_d;

  // Decode the freshly encoded value; it must reproduce bin_in.
  gray_to_bin_comb #(
    .WIDTH (WIDTH)
  ) u_chk_dec (
    .gray_i (enc_gray),
    .bin_o  (chk_bin)
  );

  // Sticky mismatch flag, set alongside the sample it flags.
  always_comb begin
    chk_err_d = chk_err_q | (in_valid && (chk_bin != bin_in));
  end

  // Checker flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_err_q <= 1'b0;
    end else begin
      chk_err_q <= chk_err_d;
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_codec.sv
// Self-checking bench for gray_codec: scoreboard queue plus monitor,
// reference model built from the reflected-binary Gray table.
module tb_gray_codec;

  localparam int W = 4;
  localparam int N = 1 << W;

  typedef struct packed {
    logic [W-1:0] g;
    logic [W-1:0] b;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] bin_in;
  logic [W-1:0] gray_in;
  logic         out_valid;
  logic [W-1:0] gray_out;
  logic [W-1:0] bin_out;
  logic         chk_err;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b1;

  exp_t         sb[$];
  logic [W-1:0] gtab[N];  // gtab[b] = Gray code of b
  int           ginv[N];  // ginv[g] = binary value of Gray code g

  always #5 clk = ~clk;

  gray_codec #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .bin_in    (bin_in),
    .gray_in   (gray_in),
    .out_valid (out_valid),
    .gray_out  (gray_out),
    .bin_out   (bin_out),
    .chk_err   (chk_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reflected-binary construction: mirror the table and set the next bit.
  task automatic build_model();
    int n;
    gtab[0] = '0;
    n = 1;
    for (int bit_i = 0; bit_i < W; bit_i++) begin
      for (int k = 0; k < n; k++) begin
        gtab[n + k] = gtab[n - 1 - k] | W'(1 << bit_i);
      end
      n = n * 2;
    end
    for (int k = 0; k < N; k++) ginv[gtab[k]] = k;
  endtask

  // Drive one cycle of inputs; exp_b < 0 means use the model decode of g.
  task automatic step(input logic v, input logic [W-1:0] b, input logic [W-1:0] g,
                      input logic r, input int exp_b);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    bin_in   = b;
    gray_in  = g;
    rst      = r;
    if (v && !r) begin
      e.g = gtab[b];
      e.b = (exp_b < 0) ? W'(ginv[g]) : W'(exp_b);
      sb.push_back(e);
    end
  endtask

  // Monitor: checks every edge against the scoreboard or the held values.
  initial begin
    logic [W-1:0] last_g;
    logic [W-1:0] last_b;
    exp_t         e;
    last_g = '0;
    last_b = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (rst) begin
          check("rst_out_valid", 32'(out_valid), 32'd0);
          check("rst_gray_out", 32'(gray_out), 32'd0);
          check("rst_bin_out", 32'(bin_out), 32'd0);
          last_g = '0;
          last_b = '0;
        end else begin
          check("out_valid", 32'(out_valid), 32'(in_valid));
          if (out_valid) begin
            if (sb.size() == 0) begin
              check("sb_nonempty", 32'd0, 32'd1);
            end else begin
              e = sb.pop_front();
              check("gray_out", 32'(gray_out), 32'(e.g));
              check("bin_out", 32'(bin_out), 32'(e.b));
              last_g = e.g;
              last_b = e.b;
            end
          end else begin
            check("hold_gray_out", 32'(gray_out), 32'(last_g));
            check("hold_bin_out", 32'(bin_out), 32'(last_b));
          end
        end
        check("chk_err", 32'(chk_err), 32'd0);
      end
    end
  end

  initial begin
    int prev_v;
    int v;
    logic [W-1:0] fb;
    build_model();

    // Reset held two edges while a sample is presented.
    rst      = 1'b1;
    in_valid = 1'b1;
    bin_in   = '1;
    gray_in  = '1;
    @(negedge clk);
    @(negedge clk);

    // Exhaustive encode and decode sweep, both lanes together.
    for (int i = 0; i < N; i++) step(1'b1, W'(i), gtab[i], 1'b0, -1);

    // Loopback: previous gray_out fed into gray_in must decode to previous bin_in.
    prev_v = N - 1;
    for (int i = 0; i < N; i++) begin
      v = (i * 7 + 3) % N;
      @(negedge clk);
      fb = gray_out;
      in_valid = 1'b1;
      bin_in   = W'(v);
      gray_in  = fb;
      rst      = 1'b0;
      sb.push_back('{g: gtab[v], b: W'(prev_v)});
      prev_v = v;
    end

    // Hold: one sample then idle cycles with changing inputs.
    step(1'b1, 4'b0101, 4'b0011, 1'b0, -1);
    step(1'b0, 4'b1111, 4'b1000, 1'b0, -1);
    step(1'b0, 4'b1010, 4'b0110, 1'b0, -1);

    // Mid-stream reset drops the sample presented with it.
    step(1'b1, 4'b1011, 4'b1110, 1'b0, -1);
    step(1'b1, 4'b0110, 4'b0101, 1'b1, -1);
    step(1'b1, 4'b1001, 4'b1101, 1'b0, -1);

    // Randomised traffic with occasional reset.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
           1'($urandom_range(0, 31) == 0), -1);
    end

    step(1'b0, '0, '0, 1'b0, -1);
    step(1'b0, '0, '0, 1'b0, -1);
    check("sb_drained", 32'(sb.size()), 32'd0);

`ifdef GRAY_CODEC_CHECK_EN
    // Corrupt the internal encode result; the checker must flag and hold it.
    mon_en = 1'b0;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b1;
    bin_in   = '0;
    force dut.enc_gray = 4'b0101;
    @(negedge clk);
    release dut.enc_gray;
    in_valid = 1'b0;
    check("chk_err_set", 32'(chk_err), 32'd1);
    repeat (3) @(negedge clk);
    check("chk_err_sticky", 32'(chk_err), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("chk_err_cleared", 32'(chk_err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
